// File: rtl/fcfs_request_issuer.sv
// FCFS DRAM request issuer: pops requests in arrival order, manages per-bank open rows,
// sequences PRE/ACT/RD/WR under tRP/tRCD and returns read data tagged with its address.
module fcfs_request_issuer #(
    parameter int T_RCD = 3,
    parameter int T_RP  = 3,
    parameter int T_CL  = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] ADDRESS_IN,
    input  logic [31:0] WRITE_DATA_IN,
    input  logic        R_W_IN,
    output logic        POP,
    output logic [2:0]  CMD,
    output logic [1:0]  CMD_BANK,
    output logic [13:0] CMD_ROW,
    output logic [9:0]  CMD_COL,
    output logic [31:0] DRAM_WDATA,
    input  logic [31:0] DRAM_RDATA,
    output logic        READ_VALID,
    output logic [31:0] READ_DATA,
    output logic [31:0] READ_ADDR,
    output logic        BUSY,
    output logic [15:0] HIT_COUNT
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam logic [3:0] RP_WAIT    = 4'(T_RP - 1);
    localparam logic [3:0] RCD_WAIT   = 4'(T_RCD - 1);
    localparam bit         RP_DIRECT  = (T_RP == 32'sd1);
    localparam bit         RCD_DIRECT = (T_RCD == 32'sd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_WAIT_RP,
        S_ACTIVATE,
        S_WAIT_RCD,
        S_ISSUE
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_lat_r;
    logic        rw_r;
    logic [3:0]  open_r;
    logic [13:0] open_row_r [4];
    logic [3:0]  wait_cnt_r;
    logic [15:0] hit_count_r;

    logic        pop_r;
    logic [2:0]  cmd_r;
    logic [1:0]  cmd_bank_r;
    logic [13:0] cmd_row_r;
    logic [9:0]  cmd_col_r;
    logic [31:0] dram_wdata_r;
    logic        busy_r;

    logic [T_CL-1:0] pipe_valid_r;
    logic [31:0]     pipe_addr_r [T_CL];
    logic            read_valid_r;
    logic [31:0]     read_data_r;
    logic [31:0]     read_addr_r;

    logic [31:0] src_addr_s;
    logic [31:0] src_data_s;
    logic        src_rw_s;
    logic [1:0]  src_bank_s;
    logic [13:0] src_row_s;
    logic [9:0]  src_col_s;
    logic        row_hit_s;
    logic [2:0]  issue_cmd_s;
    logic [31:0] issue_wdata_s;
    logic        unused_addr_bits_s;

    // In IDLE the FIFO head is decoded directly; afterwards only the latched copy is used.
    always_comb begin
        src_addr_s = addr_r;
        src_data_s = wdata_lat_r;
        src_rw_s   = rw_r;
        if (state_r == S_IDLE) begin
            src_addr_s = ADDRESS_IN;
            src_data_s = WRITE_DATA_IN;
            src_rw_s   = R_W_IN;
        end else begin
            src_addr_s = addr_r;
            src_data_s = wdata_lat_r;
            src_rw_s   = rw_r;
        end
        src_col_s          = src_addr_s[11:2];
        src_bank_s         = src_addr_s[13:12];
        src_row_s          = src_addr_s[27:14];
        unused_addr_bits_s = ^{src_addr_s[31:28], src_addr_s[1:0]};
        row_hit_s          = open_r[src_bank_s] && (open_row_r[src_bank_s] == src_row_s);
        if (src_rw_s) begin
            issue_cmd_s   = CMD_WR;
            issue_wdata_s = src_data_s;
        end else begin
            issue_cmd_s   = CMD_RD;
            issue_wdata_s = 32'd0;
        end
    end

    // Main sequencer: state, bank table, hit counter and registered command outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= S_IDLE;
            addr_r       <= 32'd0;
            wdata_lat_r  <= 32'd0;
            rw_r         <= 1'b0;
            open_r       <= 4'd0;
            for (int b = 0; b < 4; b++) begin
                open_row_r[b] <= 14'd0;
            end
            wait_cnt_r   <= 4'd0;
            hit_count_r  <= 16'd0;
            pop_r        <= 1'b0;
            cmd_r        <= CMD_NOP;
            cmd_bank_r   <= 2'd0;
            cmd_row_r    <= 14'd0;
            cmd_col_r    <= 10'd0;
            dram_wdata_r <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            pop_r        <= 1'b0;
            cmd_r        <= CMD_NOP;
            cmd_bank_r   <= 2'd0;
            cmd_row_r    <= 14'd0;
            cmd_col_r    <= 10'd0;
            dram_wdata_r <= 32'd0;
            case (state_r)
                S_IDLE: begin
                    if (!FIFO_EMPTY) begin
                        addr_r      <= ADDRESS_IN;
                        wdata_lat_r <= WRITE_DATA_IN;
                        rw_r        <= R_W_IN;
                        busy_r      <= 1'b1;
                        cmd_bank_r  <= src_bank_s;
                        if (row_hit_s) begin
                            state_r      <= S_ISSUE;
                            cmd_r        <= issue_cmd_s;
                            cmd_col_r    <= src_col_s;
                            dram_wdata_r <= issue_wdata_s;
                            pop_r        <= 1'b1;
                            if (hit_count_r != 16'hFFFF) begin
                                hit_count_r <= hit_count_r + 16'd1;
                            end
                        end else if (!open_r[src_bank_s]) begin
                            state_r   <= S_ACTIVATE;
                            cmd_r     <= CMD_ACT;
                            cmd_row_r <= src_row_s;
                        end else begin
                            state_r <= S_PRECHARGE;
                            cmd_r   <= CMD_PRE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_PRECHARGE: begin
                    open_r[src_bank_s] <= 1'b0;
                    if (RP_DIRECT) begin
                        state_r    <= S_ACTIVATE;
                        cmd_r      <= CMD_ACT;
                        cmd_bank_r <= src_bank_s;
                        cmd_row_r  <= src_row_s;
                    end else begin
                        state_r    <= S_WAIT_RP;
                        wait_cnt_r <= RP_WAIT;
                    end
                end
                S_WAIT_RP: begin
                    if (wait_cnt_r == 4'd1) begin
                        state_r    <= S_ACTIVATE;
                        cmd_r      <= CMD_ACT;
                        cmd_bank_r <= src_bank_s;
                        cmd_row_r  <= src_row_s;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                S_ACTIVATE: begin
                    open_r[src_bank_s]     <= 1'b1;
                    open_row_r[src_bank_s] <= src_row_s;
                    if (RCD_DIRECT) begin
                        state_r      <= S_ISSUE;
                        cmd_r        <= issue_cmd_s;
                        cmd_bank_r   <= src_bank_s;
                        cmd_col_r    <= src_col_s;
                        dram_wdata_r <= issue_wdata_s;
                        pop_r        <= 1'b1;
                    end else begin
                        state_r    <= S_WAIT_RCD;
                        wait_cnt_r <= RCD_WAIT;
                    end
                end
                S_WAIT_RCD: begin
                    if (wait_cnt_r == 4'd1) begin
                        state_r      <= S_ISSUE;
                        cmd_r        <= issue_cmd_s;
                        cmd_bank_r   <= src_bank_s;
                        cmd_col_r    <= src_col_s;
                        dram_wdata_r <= issue_wdata_s;
                        pop_r        <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return tag pipeline; data is captured when a tag reaches the last stage.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pipe_valid_r <= '0;
            for (int i = 0; i < T_CL; i++) begin
                pipe_addr_r[i] <= 32'd0;
            end
            read_valid_r <= 1'b0;
            read_data_r  <= 32'd0;
            read_addr_r  <= 32'd0;
        end else begin
            pipe_valid_r[0] <= (state_r == S_ISSUE) && !rw_r;
            pipe_addr_r[0]  <= addr_r;
            for (int i = 1; i < T_CL; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_addr_r[i]  <= pipe_addr_r[i-1];
            end
            if (pipe_valid_r[T_CL-1]) begin
                read_valid_r <= 1'b1;
                read_data_r  <= DRAM_RDATA;
                read_addr_r  <= pipe_addr_r[T_CL-1];
            end else begin
                read_valid_r <= 1'b0;
                read_data_r  <= 32'd0;
                read_addr_r  <= 32'd0;
            end
        end
    end

    assign POP        = pop_r;
    assign CMD        = cmd_r;
    assign CMD_BANK   = cmd_bank_r;
    assign CMD_ROW    = cmd_row_r;
    assign CMD_COL    = cmd_col_r;
    assign DRAM_WDATA = dram_wdata_r;
    assign BUSY       = busy_r;
    assign HIT_COUNT  = hit_count_r;
    assign READ_VALID = read_valid_r;
    assign READ_DATA  = read_data_r;
    assign READ_ADDR  = read_addr_r;

endmodule

// File: tb/tb_fcfs_request_issuer.sv
// Scoreboard bench for fcfs_request_issuer: a FIFO model feeds requests, a bank model predicts
// the command stream and read responses, and a DRAM stub returns cycle-stamped read data.
module tb_fcfs_request_issuer;

    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_CL  = 4;

    logic        CLK;
    logic        RESET_N;
    logic        FIFO_EMPTY;
    logic [31:0] ADDRESS_IN;
    logic [31:0] WRITE_DATA_IN;
    logic        R_W_IN;
    logic        POP;
    logic [2:0]  CMD;
    logic [1:0]  CMD_BANK;
    logic [13:0] CMD_ROW;
    logic [9:0]  CMD_COL;
    logic [31:0] DRAM_WDATA;
    logic [31:0] DRAM_RDATA;
    logic        READ_VALID;
    logic [31:0] READ_DATA;
    logic [31:0] READ_ADDR;
    logic        BUSY;
    logic [15:0] HIT_COUNT;

    fcfs_request_issuer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FIFO_EMPTY(FIFO_EMPTY), .ADDRESS_IN(ADDRESS_IN),
        .WRITE_DATA_IN(WRITE_DATA_IN), .R_W_IN(R_W_IN), .POP(POP), .CMD(CMD),
        .CMD_BANK(CMD_BANK), .CMD_ROW(CMD_ROW), .CMD_COL(CMD_COL), .DRAM_WDATA(DRAM_WDATA),
        .DRAM_RDATA(DRAM_RDATA), .READ_VALID(READ_VALID), .READ_DATA(READ_DATA),
        .READ_ADDR(READ_ADDR), .BUSY(BUSY), .HIT_COUNT(HIT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [13:0] row;
        logic [9:0]  col;
        logic [31:0] wdata;
        logic        pop;
    } cmd_t;
    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
    } req_t;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];
    req_t fifo_q[$];

    int          cyc;
    int          n_cmp;
    int          n_err;
    logic        m_open [4];
    logic [13:0] m_row [4];
    int          m_hits;

    function automatic logic [31:0] rd_pat(input int c);
        return 32'hC0DE_0000 + 32'(c);
    endfunction

    task automatic set_head();
        FIFO_EMPTY = (fifo_q.size() == 0);
        if (fifo_q.size() == 0) begin
            ADDRESS_IN    = 32'hFFFF_FFFF;
            WRITE_DATA_IN = 32'hFFFF_FFFF;
            R_W_IN        = 1'b1;
        end else begin
            ADDRESS_IN    = fifo_q[0].addr;
            WRITE_DATA_IN = fifo_q[0].data;
            R_W_IN        = fifo_q[0].rw;
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
            m_row[b]  = 14'd0;
        end
        m_hits = 0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
    endtask

    task automatic enqueue(input logic [31:0] addr, input logic [31:0] data, input logic rw);
        fifo_q.push_back(req_t'{addr, data, rw});
        set_head();
    endtask

    // Predict commands for a request whose head is seen in IDLE at cycle t.
    task automatic expect_req(input logic [31:0] addr, input logic [31:0] data, input logic rw,
                              input int t, output int rdwr);
        logic [1:0]  bank;
        logic [13:0] row;
        logic [9:0]  col;
        bank = addr[13:12];
        row  = addr[27:14];
        col  = addr[11:2];
        if (m_open[bank] && m_row[bank] == row) begin
            rdwr = t + 1;
            if (m_hits < 65535) m_hits++;
        end else if (!m_open[bank]) begin
            exp_cmd_q.push_back(cmd_t'{t + 1, 3'd1, bank, row, 10'd0, 32'd0, 1'b0});
            rdwr = t + 1 + T_RCD;
        end else begin
            exp_cmd_q.push_back(cmd_t'{t + 1, 3'd4, bank, 14'd0, 10'd0, 32'd0, 1'b0});
            exp_cmd_q.push_back(cmd_t'{t + 1 + T_RP, 3'd1, bank, row, 10'd0, 32'd0, 1'b0});
            rdwr = t + 1 + T_RP + T_RCD;
        end
        m_open[bank] = 1'b1;
        m_row[bank]  = row;
        exp_cmd_q.push_back(cmd_t'{rdwr, rw ? 3'd3 : 3'd2, bank, 14'd0, col,
                                   rw ? data : 32'd0, 1'b1});
        if (!rw) exp_rsp_q.push_back(rsp_t'{rdwr + T_CL + 1, addr, rd_pat(rdwr + T_CL)});
    endtask

    // One clock: score outputs at the falling edge, then update FIFO and DRAM stimulus.
    task automatic step();
        cmd_t e;
        rsp_t r;
        @(negedge CLK);
        cyc++;
        while (exp_cmd_q.size() > 0 && exp_cmd_q[0].cyc < cyc) begin
            e = exp_cmd_q.pop_front();
            n_cmp++; n_err++;
            $display("FAIL cmd_missing: required cmd=%0d at cyc %0d, actual nothing issued", e.cmd, e.cyc);
        end
        while (exp_rsp_q.size() > 0 && exp_rsp_q[0].cyc < cyc) begin
            r = exp_rsp_q.pop_front();
            n_cmp++; n_err++;
            $display("FAIL rsp_missing: required addr=%h at cyc %0d, actual none", r.addr, r.cyc);
        end
        n_cmp++;
        if (CMD !== 3'd0 || POP !== 1'b0) begin
            if (exp_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd_unexpected cyc %0d: actual cmd=%0d pop=%b, required none", cyc, CMD, POP);
            end else begin
                e = exp_cmd_q.pop_front();
                if (e.cyc != cyc || CMD !== e.cmd || CMD_BANK !== e.bank || CMD_ROW !== e.row ||
                    CMD_COL !== e.col || DRAM_WDATA !== e.wdata || POP !== e.pop) begin
                    n_err++;
                    $display("FAIL cmd_stream: actual cyc=%0d cmd=%0d bank=%0d row=%0d col=%0d wd=%h pop=%b, required cyc=%0d cmd=%0d bank=%0d row=%0d col=%0d wd=%h pop=%b",
                             cyc, CMD, CMD_BANK, CMD_ROW, CMD_COL, DRAM_WDATA, POP,
                             e.cyc, e.cmd, e.bank, e.row, e.col, e.wdata, e.pop);
                end
            end
        end else if ({CMD_BANK, CMD_ROW, CMD_COL, DRAM_WDATA} !== 58'd0) begin
            n_err++;
            $display("FAIL nop_fields cyc %0d: actual bank=%0d row=%0d col=%0d wd=%h, required all 0",
                     cyc, CMD_BANK, CMD_ROW, CMD_COL, DRAM_WDATA);
        end
        if (POP === 1'b1) begin
            n_cmp++;
            if (FIFO_EMPTY !== 1'b0) begin
                n_err++;
                $display("FAIL pop_when_empty cyc %0d: actual POP=1, required 0", cyc);
            end
        end
        if (READ_VALID === 1'b1) begin
            n_cmp++;
            if (exp_rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected cyc %0d: actual addr=%h data=%h, required none", cyc, READ_ADDR, READ_DATA);
            end else begin
                r = exp_rsp_q.pop_front();
                if (r.cyc != cyc || READ_ADDR !== r.addr || READ_DATA !== r.data) begin
                    n_err++;
                    $display("FAIL rsp_stream: actual cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                             cyc, READ_ADDR, READ_DATA, r.cyc, r.addr, r.data);
                end
            end
        end
        if (POP === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
        set_head();
        DRAM_RDATA = rd_pat(cyc);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_cmd_q.size() > 0 || exp_rsp_q.size() > 0 || fifo_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        if (exp_cmd_q.size() > 0 || exp_rsp_q.size() > 0 || fifo_q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: actual pending cmd=%0d rsp=%0d fifo=%0d, required 0/0/0",
                     exp_cmd_q.size(), exp_rsp_q.size(), fifo_q.size());
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if ({POP, CMD, CMD_BANK, CMD_ROW, CMD_COL, DRAM_WDATA, READ_VALID, READ_DATA, READ_ADDR, BUSY, HIT_COUNT} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: actual cmd=%0d pop=%b busy=%b hits=%0d rv=%b, required all 0",
                     CMD, POP, BUSY, HIT_COUNT, READ_VALID);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_empty();
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (CMD !== 3'd0 || POP !== 1'b0 || BUSY !== 1'b0) begin
                n_err++;
                $display("FAIL empty_idle cyc %0d: actual cmd=%0d pop=%b busy=%b, required 0/0/0", cyc, CMD, POP, BUSY);
            end
        end
    endtask

    task automatic test_cold_read();
        int r;
        enqueue(32'h0001_4010, 32'h0, 1'b0);
        expect_req(32'h0001_4010, 32'h0, 1'b0, cyc, r);
        step();
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL cold_busy: actual %b, required 1", BUSY);
        end
        drain(60);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL cold_hits: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    task automatic test_hit_write();
        int r;
        enqueue(32'h0001_4014, 32'hDEAD_BEEF, 1'b1);
        expect_req(32'h0001_4014, 32'hDEAD_BEEF, 1'b1, cyc, r);
        drain(60);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL hit_write_count: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        int t;
        int r;
        a[0] = 32'h0001_4020;
        a[1] = 32'h0001_4030;
        a[2] = 32'h0001_4FF0;
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            enqueue(a[i], 32'h0, 1'b0);
            expect_req(a[i], 32'h0, 1'b0, t, r);
            t = r + 1;
        end
        drain(80);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL b2b_hits: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    task automatic test_miss();
        int r;
        enqueue(32'h0001_8010, 32'h0, 1'b0);
        expect_req(32'h0001_8010, 32'h0, 1'b0, cyc, r);
        drain(60);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL miss_hits: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    task automatic test_banks();
        req_t rq [3];
        int t;
        int r;
        rq[0] = req_t'{32'hA001_1FFF, 32'h0, 1'b0};
        rq[1] = req_t'{32'h0001_8000, 32'h1234_5678, 1'b1};
        rq[2] = req_t'{32'h0001_7FFC, 32'h0, 1'b0};
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            enqueue(rq[i].addr, rq[i].data, rq[i].rw);
            expect_req(rq[i].addr, rq[i].data, rq[i].rw, t, r);
            t = r + 1;
        end
        drain(80);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL banks_hits: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    task automatic test_reset_mid_act();
        int r1;
        int r2;
        int n;
        enqueue(32'h0001_8004, 32'h0, 1'b0);
        enqueue(32'hF002_601F, 32'h0, 1'b0);
        expect_req(32'h0001_8004, 32'h0, 1'b0, cyc, r1);
        expect_req(32'hF002_601F, 32'h0, 1'b0, r1 + 1, r2);
        n = 0;
        while (cyc < r1 + 2 && n < 20) begin
            step();
            n++;
        end
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if ({POP, CMD, CMD_BANK, CMD_ROW, CMD_COL, DRAM_WDATA, READ_VALID, READ_DATA, READ_ADDR, BUSY, HIT_COUNT} !== '0) begin
            n_err++;
            $display("FAIL reset_async: actual cmd=%0d row=%0d pop=%b busy=%b hits=%0d, required all 0",
                     CMD, CMD_ROW, POP, BUSY, HIT_COUNT);
        end
        model_reset();
        for (int i = 0; i < 3; i++) step();
        RESET_N = 1'b1;
        expect_req(32'hF002_601F, 32'h0, 1'b0, cyc, r2);
        drain(60);
        n_cmp++;
        if (HIT_COUNT !== 16'(m_hits)) begin
            n_err++;
            $display("FAIL reset_hits: actual %0d, required %0d", HIT_COUNT, m_hits);
        end
    endtask

    initial begin
        RESET_N    = 1'b0;
        DRAM_RDATA = 32'd0;
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        model_reset();
        set_head();
        test_reset();
        test_empty();
        test_cold_read();
        test_hit_write();
        test_back_to_back();
        test_miss();
        test_banks();
        test_reset_mid_act();
        test_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
